// File: rtl/crc_frame_tx.sv
// crc_frame_tx: bit-serial frame transmitter, sends sync word, payload bytes and the CRC-16/XMODEM
// value from an external crc16 instance, MSB first.
module crc_frame_tx #(
    parameter int                    SYNC_WIDTH = 8,
    parameter logic [SYNC_WIDTH-1:0] SYNC_WORD  = 8'h7E,
    parameter int                    GAP_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic        tx_data,
    output logic        tx_en,
    output logic        crc_din,
    output logic        crc_rst_n,
    input  logic [15:0] crc_value,
    output logic        busy,
    output logic        underrun
);
    localparam int CW = $clog2(SYNC_WIDTH > 16 ? SYNC_WIDTH : 16);
    localparam int GW = $clog2(GAP_CYCLES) + 1;
    localparam logic [CW-1:0] SYNC_END = CW'(SYNC_WIDTH - 1);
    localparam logic [CW-1:0] BYTE_END = CW'(7);
    localparam logic [CW-1:0] CRC_END  = CW'(15);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, SYNC, PAYLOAD, CRC, GAP} state_t;

    state_t                state, nxt;
    logic [CW-1:0]         cnt;
    logic [GW-1:0]         gap_cnt;
    logic [7:0]            shifter;
    logic                  last;
    logic [SYNC_WIDTH-1:0] sync_sr;
    logic [15:0]           crc_shift;
    logic                  handshake;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= GAP;
        else          state <= nxt;
    end

    always_comb begin
        nxt      = state;
        s_ready  = 1'b0;
        tx_en    = 1'b0;
        tx_data  = 1'b0;
        underrun = 1'b0;
        unique case (state)
            IDLE: begin
                s_ready = 1'b1;
                nxt     = s_valid ? SYNC : IDLE;
            end
            SYNC: begin
                tx_en   = 1'b1;
                tx_data = sync_sr[SYNC_WIDTH-1];
                nxt     = (cnt == SYNC_END) ? PAYLOAD : SYNC;
            end
            PAYLOAD: begin
                tx_en   = 1'b1;
                tx_data = shifter[7];
                s_ready = (cnt == BYTE_END) && !last;
                if (cnt == BYTE_END && last) nxt = CRC;
                else if (cnt == BYTE_END && !s_valid) begin
                    underrun = 1'b1;
                    nxt      = GAP;
                end
            end
            CRC: begin
                tx_en   = 1'b1;
                // The first CRC bit comes straight from crc16; it settled on the last payload edge.
                tx_data = (cnt == '0) ? crc_value[15] : crc_shift[15];
                nxt     = (cnt == CRC_END) ? GAP : CRC;
            end
            GAP: nxt = (gap_cnt == '0) ? IDLE : GAP;
            default: nxt = GAP;
        endcase
    end

    assign handshake = s_valid && s_ready;
    assign crc_din   = (state == PAYLOAD) && tx_data;
    assign busy      = state != IDLE;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            gap_cnt   <= '0;
            shifter   <= '0;
            last      <= 1'b0;
            sync_sr   <= '0;
            crc_shift <= '0;
            crc_rst_n <= 1'b0;
        end else begin
            crc_rst_n <= (nxt == PAYLOAD) || (nxt == CRC);
            cnt       <= (nxt != state || (state == PAYLOAD && cnt == BYTE_END)) ? '0 : cnt + CW'(1);
            gap_cnt   <= (nxt == GAP && state != GAP) ? GAP_LOAD : (gap_cnt == '0) ? '0 : gap_cnt - GW'(1);
            shifter   <= handshake ? s_data : (state == PAYLOAD) ? {shifter[6:0], 1'b0} : shifter;
            last      <= handshake ? s_last : last;
            sync_sr   <= (state == IDLE) ? SYNC_WORD : (state == SYNC) ? sync_sr << 1 : sync_sr;
            crc_shift <= (state == CRC && cnt == '0) ? crc_value << 1 : crc_shift << 1;
        end
    end
endmodule

// File: tb/tb_crc_frame_tx.sv
// tb_crc_frame_tx: directed frames against hand-computed CRC-16/XMODEM values, with a
// behavioural crc16 standing in for the external instance.
module tb_crc_frame_tx;
    localparam int GAP_CYCLES = 4;
    localparam int IDLE_BETWEEN = GAP_CYCLES + 1;

    logic        clk, reset_n;
    logic [7:0]  s_data;
    logic        s_valid, s_last, s_ready;
    logic        tx_data, tx_en, crc_din, crc_rst_n, busy, underrun;
    logic [15:0] crc_value;

    int tests = 0, fails = 0;

    crc_frame_tx #(.SYNC_WIDTH(8), .SYNC_WORD(8'h7E), .GAP_CYCLES(GAP_CYCLES)) dut (
        .clk(clk), .reset_n(reset_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .tx_data(tx_data), .tx_en(tx_en), .crc_din(crc_din),
        .crc_rst_n(crc_rst_n), .crc_value(crc_value), .busy(busy), .underrun(underrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (!crc_rst_n) crc_value <= 16'h0000;
        else crc_value <= {crc_value[14:0], 1'b0} ^ ((crc_value[15] ^ crc_din) ? 16'h1021 : 16'h0000);
    end

    logic [255:0] fbits [32];
    int           flen [32];
    int           gaps [32];
    logic [255:0] cur = '0;
    int           cur_len = 0, low = 0, fc = 0, und = 0;
    logic         prev_en = 1'b0;

    always @(negedge clk) begin
        if (tx_en === 1'b1) begin
            if (!prev_en && fc < 32) gaps[fc] = low;
            cur = {cur[254:0], tx_data};
            cur_len++;
        end else begin
            if (prev_en && fc < 32) begin
                fbits[fc] = cur;
                flen[fc]  = cur_len;
                fc++;
                cur = '0;
                cur_len = 0;
                low = 0;
            end
            low++;
        end
        if (underrun === 1'b1) und++;
        prev_en = (tx_en === 1'b1);
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b, input logic l);
        int n = 0;
        logic hs = 1'b0;
        s_data = b;
        s_valid = 1'b1;
        s_last = l;
        while (!hs && n < 400) begin
            #1 hs = s_ready;
            @(negedge clk);
            n++;
        end
        chk("push_accept", 256'(hs), 256'(1));
    endtask

    task automatic send(input logic [7:0] q[$], input logic keep);
        foreach (q[i]) push(q[i], i == q.size() - 1);
        if (!keep) begin
            s_valid = 1'b0;
            s_last = 1'b0;
        end
    endtask

    task automatic wait_frames(input int target);
        int n = 0;
        while (fc < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("frame_timeout", 256'(fc >= target), 256'(1));
    endtask

    function automatic logic [255:0] frame_vec(input logic [7:0] q[$], input logic [15:0] crc, input logic with_crc);
        logic [255:0] v = 256'(8'h7E);
        foreach (q[i]) v = (v << 8) | 256'(q[i]);
        return with_crc ? (v << 16) | 256'(crc) : v;
    endfunction

    task automatic check_frame(input string tag, input int idx, input logic [255:0] exp_v, input int exp_len);
        chk({tag, "_len"}, 256'(flen[idx]), 256'(exp_len));
        chk({tag, "_bits"}, fbits[idx], exp_v);
    endtask

    logic [7:0] q_check[$], q_one[$], q_zero[$], q_ur[$];
    int   idx;
    logic bad;

    initial begin
        q_check = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        q_one   = '{8'h01};
        q_zero  = '{8'h00};
        q_ur    = '{8'h11, 8'h22};
        s_data = '0;
        s_valid = 1'b0;
        s_last = 1'b0;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_vals", 256'({s_ready, tx_data, tx_en, crc_din, crc_rst_n, busy, underrun}), 256'(7'b0000010));
        reset_n = 1'b1;
        #1 chk("ready_at_release", 256'(s_ready), 256'(0));
        @(negedge clk);
        chk("ready_after_release", 256'({s_ready, busy}), 256'(2'b10));

        bad = 1'b0;
        repeat (100) begin
            @(negedge clk);
            bad |= tx_en | busy | crc_rst_n;
        end
        chk("idle_stall", 256'(bad), 256'(0));

        idx = fc;
        push(8'h01, 1'b1);
        chk("start_after_hs", 256'({tx_en, busy}), 256'(2'b11));
        s_valid = 1'b0;
        s_last = 1'b0;
        wait_frames(idx + 1);
        check_frame("one", idx, frame_vec(q_one, 16'h1021, 1'b1), 32);

        idx = fc;
        send(q_zero, 1'b0);
        wait_frames(idx + 1);
        check_frame("zero", idx, frame_vec(q_zero, 16'h0000, 1'b1), 32);

        idx = fc;
        send(q_check, 1'b0);
        wait_frames(idx + 1);
        check_frame("check", idx, frame_vec(q_check, 16'h31C3, 1'b1), 96);

        idx = fc;
        send(q_check, 1'b1);
        send(q_one, 1'b0);
        wait_frames(idx + 2);
        check_frame("b2b_a", idx, frame_vec(q_check, 16'h31C3, 1'b1), 96);
        check_frame("b2b_b", idx + 1, frame_vec(q_one, 16'h1021, 1'b1), 32);
        chk("b2b_gap", 256'(gaps[idx + 1]), 256'(IDLE_BETWEEN));
        chk("no_underrun_yet", 256'(und), 256'(0));

        idx = fc;
        push(8'h11, 1'b0);
        push(8'h22, 1'b0);
        s_valid = 1'b0;
        wait_frames(idx + 1);
        check_frame("underrun", idx, frame_vec(q_ur, 16'h0000, 1'b0), 24);
        repeat (10) @(negedge clk);
        chk("underrun_pulses", 256'(und), 256'(1));
        idx = fc;
        send(q_one, 1'b0);
        wait_frames(idx + 1);
        check_frame("after_ur", idx, frame_vec(q_one, 16'h1021, 1'b1), 32);

        repeat (8) @(negedge clk);
        push(8'h31, 1'b0);
        repeat (11) @(negedge clk);
        chk("pre_reset", 256'({tx_en, crc_rst_n, busy}), 256'(3'b111));
        reset_n = 1'b0;
        #1 chk("mid_reset", 256'({tx_en, crc_rst_n, s_ready, busy}), 256'(4'b0001));
        s_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1 chk("rst2_release", 256'(s_ready), 256'(0));
        @(negedge clk);
        chk("rst2_ready", 256'(s_ready), 256'(1));
        idx = fc;
        send(q_check, 1'b0);
        wait_frames(idx + 1);
        check_frame("after_rst", idx, frame_vec(q_check, 16'h31C3, 1'b1), 96);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
